// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder that drives one full-adder cell over
// WIDTH cycles, LSB first, and reports the result with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add a signed-overflow
// output (ovf) that is updated together with sum/cout.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-adder cell working on the current LSBs and the carry register.
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] acc_next;
  logic             capture;

  assign fa_s     = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c     = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & c_q);
  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign acc_next = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  // start is honoured only when no addition is running.
  assign capture  = start && (state_q != RUN);

  // State and datapath registers, all cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state, datapath update and status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: ;
      RUN: begin
        busy  = 1'b1;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Result registers move only on the completion edge.
          state_d = DONE;
          sum_d   = acc_next;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB at this point.
          ovf_d   = c_q ^ fa_c;
`endif
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      a_d     = a;
      b_d     = b;
      c_d     = cin;
      cnt_d   = '0;
      acc_d   = '0;
      state_d = RUN;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the main
// sequences and a 1-bit instance for the exhaustive single-bit case.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] prev_sum  = 8'h00;
  logic       prev_cout = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One 8-bit addition; rk>0 re-pulses start (with a different a) at RUN cycle rk.
  task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input logic [7:0] es, input logic ec,
                      input logic eo, input int rk);
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start8 = 1'b0; a8 = ~ia; b8 = ~ib; cin8 = ~ic;
      end
      if (rk > 0 && k == rk) begin
        start8 = 1'b1; a8 = 8'h11;
      end
      if (rk > 0 && k == rk + 1) start8 = 1'b0;
      check_eq({tag, "_busy"}, {busy8, done8}, 2'b10);
    end
    check_eq({tag, "_hold"}, {cout8, sum8}, {prev_cout, prev_sum});
    @(negedge clk);
    check_eq({tag, "_done"}, {busy8, done8}, 2'b01);
    check_eq({tag, "_sum"}, sum8, es);
    check_eq({tag, "_cout"}, cout8, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq({tag, "_ovf"}, ovf8, eo);
`else
    if (eo) ; // overflow expectation only meaningful with the ovf port
`endif
    prev_sum = es; prev_cout = ec;
    @(negedge clk);
    check_eq({tag, "_idle"}, {busy8, done8, cout8, sum8}, {2'b00, ec, es});
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst8", {busy8, done8, cout8, sum8}, 11'h0);
    check_eq("rst1", {busy1, done1, cout1, sum1}, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle8", {busy8, done8}, 2'b00);

    run8("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    run8("ff01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run8("a55a",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run8("7f01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run8("80ff",  8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 0);
    run8("repls", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 3);

    // Reset in the middle of RUN: outputs clear at once, no done afterwards.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    check_eq("pre_rst_busy", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst", {busy8, done8, cout8, sum8}, 11'h0);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("midrst_ovf", ovf8, 1'b0);
`endif
    prev_sum = 8'h00; prev_cout = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) rst_n = 1'b1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    check_eq("no_done_after_rst", saw_done, 1'b0);
    run8("post", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

    // WIDTH=1, all 8 input combinations, each new start issued while in DONE.
    @(negedge clk);
    {a1, b1, cin1} = 3'd0; start1 = 1'b1;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vec;
      logic [1:0] exp;
      vec = 3'(v);
      exp = 2'(vec[2]) + 2'(vec[1]) + 2'(vec[0]);
      @(negedge clk);
      start1 = 1'b0;
      check_eq($sformatf("w1_busy%0d", v), {busy1, done1}, 2'b10);
      @(negedge clk);
      check_eq($sformatf("w1_done%0d", v), {busy1, done1}, 2'b01);
      check_eq($sformatf("w1_res%0d", v), {cout1, sum1}, exp);
      if (v < 7) begin
        {a1, b1, cin1} = 3'(v + 1); start1 = 1'b1;
      end
    end
    @(negedge clk);
    check_eq("w1_idle", {busy1, done1}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition, sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured with start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured with start.
REQ-007 SHALL have port cin  input  1  carry-in, captured with start.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is complete.
REQ-010 SHALL have port sum  output  WIDTH  result of a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  carry-out of the result.

Function
REQ-012 SHALL sequence one single-bit full-adder cell (s = x^y^c; c' = x&y | (x^y)&c) over WIDTH cycles, LSB first.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, with a bit counter of width clog2(WIDTH+1).
REQ-014 SHALL accept start in IDLE or DONE, capturing a, b and cin and clearing the counter, then enter RUN.
REQ-015 SHALL process exactly one bit per cycle in RUN, using a shift register for the operands and a carry register.
REQ-016 SHALL go RUN->DONE on the edge that processes bit WIDTH-1, loading sum and cout on that same edge.
REQ-017 SHALL hold busy=1 exactly WIDTH cycles; done=1 SHALL assert exactly WIDTH edges after the capture edge.
REQ-018 SHALL keep done=1 for exactly one cycle (DONE state), then go DONE->IDLE unless start=1, in which case DONE->RUN.
REQ-019 SHALL ignore start while in RUN, with no effect on the operands, the counter or the outputs.
REQ-020 SHALL hold the previous sum and cout stable during RUN and IDLE; they change only on the completion edge.
REQ-021 SHALL ignore changes on a, b and cin after the capture edge.
REQ-022 SHALL, for WIDTH=1, take one RUN cycle, with done following on the next edge.

Reset
REQ-023 SHALL, on rst_n=0, immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0 and internal registers=0.
REQ-024 SHALL abort an operation in progress on reset mid-RUN, with no done pulse.
REQ-025 SHALL sample start only on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, when macro SERIAL_ADDER_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow, equal to the carry into the MSB XOR cout.
REQ-027 SHALL update ovf only on the completion edge, and reset ovf to 0.
REQ-028 SHALL, without SERIAL_ADDER_OVF_EN, have no ovf port and no overflow logic; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover WIDTH=8, a=0x00, b=0x00, cin=0, start pulse -> busy for 8 cycles, done on the 8th edge, sum=0x00, cout=0.
REQ-030 SHALL cover WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-031 SHALL cover WIDTH=8 with SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; then a=0x80, b=0xFF -> sum=0x7F, cout=1, ovf=1.
REQ-032 SHALL cover start re-pulsed at cycle 3 of RUN with a=0x11 (original a=0x03, b=0x04) -> ignored, sum=0x07 at the original done time.
REQ-033 SHALL cover rst_n low at cycle 4 of RUN -> outputs are 0 at once, no done, next start completes normally.
REQ-034 SHALL cover WIDTH=1 exhaustive over all 8 combinations of a, b and cin -> {cout,sum}=a+b+cin, done 1 edge after capture; back-to-back start in DONE is accepted.
